// File: rtl/fc_layer.sv
// Dense layer: streams the flattened vector against weights, adds bias,
// rounds, saturates and optionally clamps negatives, one result per neuron.
module fc_layer #(
  parameter int IN_LEN  = 2048,
  parameter int OUT_LEN = 10,
  parameter int RELU    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        fl_rd,
  output logic [10:0] fl_addr,
  input  logic [19:0] fl_data,
  output logic [15:0] w_addr,
  input  logic [19:0] w_data,
  output logic [3:0]  b_addr,
  input  logic [19:0] b_data,
  output logic        out_wr,
  output logic [3:0]  out_addr,
  output logic [19:0] out_data
);

  typedef enum logic [2:0] {
    IDLE, MAC, DRAIN, BIAS, WRITE, DONE
  } state_t;

  localparam logic [10:0] I_LAST = 11'(IN_LEN - 1);
  localparam logic [3:0]  O_LAST = 4'(OUT_LEN - 1);
  localparam logic signed [35:0] R_MAX = 36'sd524287;
  localparam logic signed [35:0] R_MIN = -36'sd524288;

  state_t state_q, state_d;
  logic [10:0] i_q, i_d;
  logic [3:0]  o_q, o_d;
  logic signed [49:0] acc_q, acc_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic out_wr_q, out_wr_d;
  logic [3:0]  out_addr_q, out_addr_d;
  logic [19:0] out_data_q, out_data_d;

  logic signed [39:0] prod;
  logic signed [49:0] prod_ext;
  logic signed [49:0] bias_ext;
  logic signed [35:0] rnd;
  logic signed [35:0] r;
  logic [19:0] res;

  assign prod     = $signed(fl_data) * $signed(w_data);
  assign prod_ext = {{10{prod[39]}}, prod};
  assign bias_ext = {{14{b_data[19]}}, b_data, 16'b0};

  // Round half toward +inf at 2^-16, then saturate and optionally clamp
  always_comb begin
    rnd = {acc_q[49], acc_q[49:15]} + 36'sd1;
    r   = rnd >>> 1;
    if (r > R_MAX)
      res = 20'h7FFFF;
    else if (r < R_MIN)
      res = 20'h80000;
    else
      res = r[19:0];
    if (RELU != 0 && res[19])
      res = 20'h00000;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_wr   = out_wr_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign fl_rd    = (state_q == MAC);
  assign fl_addr  = i_q;
  assign b_addr   = o_q;
  assign w_addr   = 16'(o_q) * 16'(IN_LEN) + {5'b0, i_q};

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      o_q        <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_wr_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      o_q        <= o_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_wr_q   <= out_wr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state sequencing through a neuron and across neurons
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = MAC;
      MAC:   if (i_q == I_LAST) state_d = DRAIN;
      DRAIN: state_d = BIAS;
      BIAS:  state_d = WRITE;
      WRITE: state_d = (o_q == O_LAST) ? DONE : MAC;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, accumulator and registered outputs
  always_comb begin
    i_d        = i_q;
    o_d        = o_q;
    acc_d      = acc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    out_wr_d   = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          o_d    = '0;
          i_d    = '0;
          acc_d  = '0;
        end
      end
      MAC: begin
        if (i_q != 11'd0) acc_d = acc_q + prod_ext;
        if (i_q != I_LAST) i_d = i_q + 11'd1;
      end
      DRAIN: acc_d = acc_q + prod_ext;
      BIAS:  acc_d = acc_q + bias_ext;
      WRITE: begin
        out_wr_d   = 1'b1;
        out_addr_d = o_q;
        out_data_d = res;
        acc_d      = '0;
        if (o_q != O_LAST) begin
          o_d = o_q + 4'd1;
          i_d = '0;
        end
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
